// File: rtl/ifmap_radr_gen_pp_pkg.sv
// Shared types and constants for the ifmap read-address generator.
// Field offsets are in units of CFG_WIDTH, counted up from the LSB.
package ifmap_radr_gen_pp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int CFG_FIELDS = 10;

  localparam int OFF_OC1    = 0;
  localparam int OFF_IC1    = 1;
  localparam int OFF_IY0    = 2;
  localparam int OFF_IX0    = 3;
  localparam int OFF_DIL    = 4;
  localparam int OFF_STRIDE = 5;
  localparam int OFF_FY     = 6;
  localparam int OFF_FX     = 7;
  localparam int OFF_OY0    = 8;
  localparam int OFF_OX0    = 9;

endpackage

// File: rtl/ifmap_radr_gen_pp_if.sv
// Config and address handshake bundle of the ifmap address generator.
// The master drives config and adr_rdy; the slave produces addresses.
interface ifmap_radr_gen_pp_if #(
  parameter int BANK_ADDR_WIDTH = 8,
  parameter int CFG_WIDTH       = 8
);
  import ifmap_radr_gen_pp_pkg::*;

  logic                            config_en;
  logic [CFG_FIELDS*CFG_WIDTH-1:0] config_data;
  logic [BANK_ADDR_WIDTH-1:0]      adr;
  logic                            adr_vld;
  logic                            adr_rdy;
  logic                            bank_sel;
  logic                            done;
  logic                            busy;

  modport master (
    output config_en, config_data, adr_rdy,
    input  adr, adr_vld, bank_sel, done, busy
  );

  modport slave (
    input  config_en, config_data, adr_rdy,
    output adr, adr_vld, bank_sel, done, busy
  );

endinterface

// File: rtl/ifmap_radr_gen_pp_loop_counter.sv
// One nested-loop level: counts 0..last on enable, flags the last count.
// Wraps back to zero by itself, so the next level only sees the flag.
module ifmap_radr_gen_pp_loop_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         wrap
);

  logic [W-1:0] count_q, count_d;

  assign wrap = (count_q == last);

  // next count: clear, wrap or increment
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/ifmap_radr_gen_pp.sv
// Ping-pong ifmap read-address generator over a six-deep conv loop nest.
// Addresses are built from per-level running bases using adders only.
module ifmap_radr_gen_pp
  import ifmap_radr_gen_pp_pkg::*;
#(
  parameter int BANK_ADDR_WIDTH = 8,
  parameter int CFG_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ifmap_radr_gen_pp_if.slave   bus
);

  localparam int AW = BANK_ADDR_WIDTH;
  localparam int CW = CFG_WIDTH;
  localparam int DW = CFG_FIELDS * CW;

  typedef logic [CW-1:0] cfg_t;
  typedef logic [AW-1:0] adr_t;

  // Levels: 0 ox0, 1 oy0, 2 fx, 3 fy, 4 ic1, 5 oc1.
  // base[k] holds the address contribution of levels >= k;
  // base[0] is the issued address.
  state_e          state_q, state_d;
  logic [DW-1:0]   shadow_q, shadow_d;
  logic            pend_q, pend_d;
  logic            bank_q, bank_d;
  cfg_t            last_q [6];
  cfg_t            last_d [6];
  adr_t            step_q [5];
  adr_t            step_d [5];
  adr_t            base_q [5];
  adr_t            base_d [5];
  logic            clr;
  logic            hs;
  logic            fin;
  logic [5:0]      en;
  logic [5:0]      wrap;
  logic [DW-1:0]   src;

  function automatic cfg_t fld(input logic [DW-1:0] d, input int off);
    return d[off*CW +: CW];
  endfunction

  function automatic cfg_t nz(input cfg_t v);
    return (v == '0) ? cfg_t'(1) : v;
  endfunction

  function automatic cfg_t lst(input cfg_t v);
    return (v == '0) ? '0 : cfg_t'(v - 1'b1);
  endfunction

  assign hs  = bus.adr_vld && bus.adr_rdy;
  assign fin = hs && (&wrap);

  assign en[0] = hs;
  assign en[1] = hs && wrap[0];
  assign en[2] = hs && (&wrap[1:0]);
  assign en[3] = hs && (&wrap[2:0]);
  assign en[4] = hs && (&wrap[3:0]);
  assign en[5] = hs && (&wrap[4:0]);

  for (genvar g = 0; g < 6; g++) begin : g_lvl
    ifmap_radr_gen_pp_loop_counter #(
      .W(CW)
    ) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (clr),
      .en   (en[g]),
      .last (last_q[g]),
      .wrap (wrap[g])
    );
  end

  assign bus.adr      = base_q[0];
  assign bus.adr_vld  = (state_q == RUN);
  assign bus.busy     = (state_q == RUN);
  assign bus.bank_sel = bank_q;
  assign bus.done     = fin;

  // A same-cycle config_en wins over the shadow at frame end.
  assign src = (state_q == IDLE || bus.config_en)
             ? bus.config_data : shadow_q;

  // next state, config shadow and incremental address bases
  always_comb begin : p_next
    logic load;
    logic hit;
    adr_t v;
    adr_t st;
    adr_t dl;
    adr_t ix;
    adr_t iy;
    load     = 1'b0;
    hit      = 1'b0;
    v        = '0;
    clr      = 1'b0;
    state_d  = state_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    bank_d   = bank_q;
    last_d   = last_q;
    step_d   = step_q;
    base_d   = base_q;
    unique case (state_q)
      IDLE: begin
        if (bus.config_en) begin
          load    = 1'b1;
          clr     = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.config_en) begin
          shadow_d = bus.config_data;
          pend_d   = 1'b1;
        end
        if (fin) begin
          bank_d = ~bank_q;
          for (int j = 0; j < 5; j++) base_d[j] = '0;
          if (bus.config_en || pend_q) begin
            load   = 1'b1;
            pend_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else if (hs) begin
          for (int k = 0; k < 5; k++) begin
            if (!hit && !wrap[k]) begin
              hit = 1'b1;
              v   = base_q[k] + step_q[k];
              for (int j = 0; j < 5; j++) begin
                if (j <= k) base_d[j] = v;
              end
            end
          end
          // only oc1 advances: replay the same sequence
          if (!hit) begin
            for (int j = 0; j < 5; j++) base_d[j] = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    st = adr_t'(nz(fld(src, OFF_STRIDE)));
    dl = adr_t'(nz(fld(src, OFF_DIL)));
    ix = adr_t'(fld(src, OFF_IX0));
    iy = adr_t'(fld(src, OFF_IY0));
    if (load) begin
      last_d[0] = lst(fld(src, OFF_OX0));
      last_d[1] = lst(fld(src, OFF_OY0));
      last_d[2] = lst(fld(src, OFF_FX));
      last_d[3] = lst(fld(src, OFF_FY));
      last_d[4] = lst(fld(src, OFF_IC1));
      last_d[5] = lst(fld(src, OFF_OC1));
      step_d[0] = st;
      step_d[1] = st * ix;
      step_d[2] = dl;
      step_d[3] = dl * ix;
      step_d[4] = ix * iy;
      for (int j = 0; j < 5; j++) base_d[j] = '0;
    end
  end

  // state, config and address registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      bank_q   <= 1'b0;
      for (int i = 0; i < 6; i++) last_q[i] <= '0;
      for (int i = 0; i < 5; i++) begin
        step_q[i] <= '0;
        base_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      bank_q   <= bank_d;
      last_q   <= last_d;
      step_q   <= step_d;
      base_q   <= base_d;
    end
  end

endmodule
